// File: rtl/sdram_line_reader.sv
// rtl/sdram_line_reader.sv - fetches one image line of 3-bit pixels from SDRAM into a line buffer
`timescale 1ns/1ps
module sdram_line_reader #(
  parameter int LINE_PIXELS    = 320,
  parameter int LINE_COUNT     = 240,
  parameter int CAS_LATENCY    = 3,
  parameter int T_RCD          = 3,
  parameter int T_RP           = 3,
  parameter int T_RFC          = 9,
  parameter int REFRESH_CYCLES = 1040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_req,
  input  logic [7:0]  line_y,
  output logic        busy,
  output logic        done,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [11:0] addr,
  output logic [1:0]  ba,
  output logic        cke,
  output logic        dq_oe,
  input  logic [15:0] dq_in,
  output logic        lb_we,
  output logic [8:0]  lb_addr,
  output logic [2:0]  lb_data
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_READ = 4'b0101;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam int RCW = $clog2(REFRESH_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE, S_REFRESH, S_RFC_WAIT, S_ACTIVATE, S_RCD_WAIT,
    S_READ, S_DRAIN, S_PRECHARGE, S_RP_WAIT, S_DONE
  } state_t;

  state_t           state, state_d;
  logic [16:0]      p, p_d, start_p;
  logic [9:0]       rd_idx, rd_idx_d;
  logic [7:0]       wait_cnt, wait_cnt_d;
  logic [3:0]       cmd, cmd_d;
  logic [11:0]      addr_d;
  logic             issue, ref_clear, done_d;
  logic [RCW-1:0]   ref_cnt;
  logic             ref_pending, ref_wrap;
  logic [CAS_LATENCY:0] vld_pipe;
  logic [8:0]       idx_pipe [CAS_LATENCY:0];
  logic             unused_dq;

  assign {cs_n, ras_n, cas_n, we_n} = cmd;
  assign ba        = 2'b00;
  assign cke       = 1'b1;
  assign dq_oe     = 1'b0;
  assign busy      = (state != S_IDLE) || ref_pending;
  assign start_p   = 17'(line_y) * 17'(LINE_PIXELS);
  assign ref_wrap  = (ref_cnt == RCW'(REFRESH_CYCLES - 1));
  assign unused_dq = ^dq_in[15:3];

  always_comb begin
    state_d    = state;
    p_d        = p;
    rd_idx_d   = rd_idx;
    wait_cnt_d = wait_cnt;
    cmd_d      = CMD_NOP;
    addr_d     = 12'd0;
    issue      = 1'b0;
    ref_clear  = 1'b0;
    done_d     = 1'b0;
    case (state)
      S_IDLE: begin
        // pending refresh holds busy high, so a simultaneous request is dropped
        if (ref_pending) begin
          state_d = S_REFRESH;
        end else if (line_req) begin
          if ({1'b0, line_y} < 9'(LINE_COUNT)) begin
            p_d      = start_p;
            rd_idx_d = 10'd0;
            state_d  = S_ACTIVATE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REFRESH: begin
        cmd_d      = CMD_REF;
        ref_clear  = 1'b1;
        wait_cnt_d = 8'(T_RFC - 1);
        state_d    = S_RFC_WAIT;
      end
      S_RFC_WAIT: begin
        if (wait_cnt <= 8'd1) state_d = S_IDLE;
        else wait_cnt_d = wait_cnt - 8'd1;
      end
      S_ACTIVATE: begin
        cmd_d      = CMD_ACT;
        addr_d     = {3'b000, p[16:8]};
        wait_cnt_d = 8'(T_RCD - 1);
        state_d    = S_RCD_WAIT;
      end
      S_RCD_WAIT: begin
        if (wait_cnt <= 8'd1) state_d = S_READ;
        else wait_cnt_d = wait_cnt - 8'd1;
      end
      S_READ: begin
        cmd_d    = CMD_READ;
        addr_d   = {4'b0000, p[7:0]};
        issue    = 1'b1;
        p_d      = p + 17'd1;
        rd_idx_d = rd_idx + 10'd1;
        if (p[7:0] == 8'hff || rd_idx == 10'(LINE_PIXELS - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (vld_pipe == '0) state_d = S_PRECHARGE;
      end
      S_PRECHARGE: begin
        cmd_d      = CMD_PRE;
        addr_d     = 12'h400;
        wait_cnt_d = 8'(T_RP - 1);
        state_d    = S_RP_WAIT;
      end
      S_RP_WAIT: begin
        if (wait_cnt <= 8'd1) state_d = (rd_idx == 10'(LINE_PIXELS)) ? S_DONE : S_ACTIVATE;
        else wait_cnt_d = wait_cnt - 8'd1;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      p        <= 17'd0;
      rd_idx   <= 10'd0;
      wait_cnt <= 8'd0;
      cmd      <= CMD_NOP;
      addr     <= 12'd0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      p        <= p_d;
      rd_idx   <= rd_idx_d;
      wait_cnt <= wait_cnt_d;
      cmd      <= cmd_d;
      addr     <= addr_d;
      done     <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      if (ref_wrap) ref_pending <= 1'b1;
      else if (ref_clear) ref_pending <= 1'b0;
    end
  end

  // each READ travels CAS_LATENCY+1 stages so capture lines up with its data on dq_in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i <= CAS_LATENCY; i++) idx_pipe[i] <= 9'd0;
      lb_we   <= 1'b0;
      lb_addr <= 9'd0;
      lb_data <= 3'd0;
    end else begin
      vld_pipe    <= {vld_pipe[CAS_LATENCY-1:0], issue};
      idx_pipe[0] <= rd_idx[8:0];
      for (int i = 1; i <= CAS_LATENCY; i++) idx_pipe[i] <= idx_pipe[i-1];
      lb_we <= vld_pipe[CAS_LATENCY];
      if (vld_pipe[CAS_LATENCY]) begin
        lb_addr <= idx_pipe[CAS_LATENCY];
        lb_data <= dq_in[2:0];
      end
    end
  end

endmodule

// File: tb/tb_sdram_line_reader.sv
// tb/tb_sdram_line_reader.sv - directed scoreboard bench for sdram_line_reader with an SDRAM read model
`timescale 1ns/1ps
module tb_sdram_line_reader;
  localparam int CL  = 3;
  localparam int LP  = 320;
  localparam int LC  = 240;
  localparam int RFC = 9;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, PRE = 4'b0010, REF = 4'b0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_req = 1'b0;
  logic [7:0]  line_y = 8'd0;
  logic        busy, done, cs_n, ras_n, cas_n, we_n, cke, dq_oe, lb_we;
  logic [11:0] addr;
  logic [1:0]  ba;
  logic [15:0] dq_in = 16'h0;
  logic [8:0]  lb_addr;
  logic [2:0]  lb_data;

  sdram_line_reader dut (
    .clk(clk), .reset(reset), .line_req(line_req), .line_y(line_y),
    .busy(busy), .done(done), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .addr(addr), .ba(ba), .cke(cke), .dq_oe(dq_oe), .dq_in(dq_in),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;
  int n_act = 0, n_rd = 0, n_pre = 0, n_ref = 0, n_we = 0, n_done = 0;
  int start_p = 0, rd_base = 0;
  logic [8:0]  row_cur = 9'd0;
  logic [11:0] sb [$];
  int          lat_q [$];
  logic [16:0] dpipe [0:CL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // one clock of SDRAM model + command monitor + line-buffer scoreboard, sampled at negedge
  task automatic tick();
    logic [3:0]  cmd;
    logic [11:0] e;
    logic [16:0] w;
    @(negedge clk);
    if (reset) begin
      sb.delete();
      lat_q.delete();
      for (int i = 0; i <= CL; i++) dpipe[i] = 17'd0;
      dq_in = 16'h0;
      return;
    end
    cmd = {cs_n, ras_n, cas_n, we_n};
    for (int i = CL; i > 0; i--) dpipe[i] = dpipe[i-1];
    dpipe[0] = 17'd0;
    case (cmd)
      NOP: ;
      ACT: begin
        n_act++;
        chk("act_row", 32'(addr), 32'((start_p + n_rd - rd_base) >> 8));
        row_cur = addr[8:0];
      end
      RD: begin
        w = {row_cur, addr[7:0]};
        chk("rd_addr", 32'(w), 32'(start_p + n_rd - rd_base));
        chk("rd_a11_8", 32'(addr[11:8]), 32'd0);
        dpipe[0] = {1'b1, w[15:0]};
        lat_q.push_back(cyc);
        n_rd++;
      end
      PRE: begin
        n_pre++;
        chk("pre_a10", 32'(addr[10]), 32'd1);
      end
      REF: n_ref++;
      default: chk("cmd_legal", 32'(cmd), 32'(NOP));
    endcase
    dq_in = dpipe[CL][16] ? dpipe[CL][15:0] : 16'hfffd;
    if (done) n_done++;
    if (lb_we) begin
      n_we++;
      if (sb.size() == 0) chk("sb_nonempty", 32'd0, 32'd1);
      else begin
        e = sb.pop_front();
        chk("lb_addr", 32'(lb_addr), 32'(e[11:3]));
        chk("lb_data", 32'(lb_data), 32'(e[2:0]));
      end
      if (lat_q.size() == 0) chk("lat_nonempty", 32'd0, 32'd1);
      else chk("we_latency", 32'(cyc - lat_q.pop_front()), 32'(CL + 1));
    end
  endtask

  task automatic sync_refresh();
    int b = n_ref;
    int t = 0;
    while (n_ref == b && t < 1300) begin tick(); t++; end
    chk("refresh_seen", 32'(n_ref != b), 32'd1);
    repeat (RFC + 2) tick();
  endtask

  task automatic start_req(input int y);
    logic [8:0] kk;
    logic [2:0] pp;
    start_p = y * LP;
    rd_base = n_rd;
    if (y < LC) begin
      for (int k = 0; k < LP; k++) begin
        kk = 9'(k);
        pp = 3'(start_p + k);
        sb.push_back({kk, pp});
      end
    end
    line_y = 8'(y);
    line_req = 1'b1;
    tick();
    line_req = 1'b0;
  endtask

  task automatic run_line(input int y, input bit mid);
    int  b_we, b_rd, b_act, b_pre, b_ref, t, rows;
    bit  got;
    sync_refresh();
    b_we = n_we; b_rd = n_rd; b_act = n_act; b_pre = n_pre; b_ref = n_ref;
    start_req(y);
    chk("busy_rise", 32'(busy), 32'd1);
    t = 1;
    got = done;
    while (!got && t < 3000) begin
      if (mid && t == 50) begin line_y = 8'(y + 1); line_req = 1'b1; end
      tick();
      line_req = 1'b0;
      t++;
      got = done;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_fall", 32'(busy), 32'd0);
    if (y >= LC) chk("done_latency", 32'(t), 32'd2);
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    rows = (y < LC) ? (((start_p % 256) + LP - 1) / 256 + 1) : 0;
    chk("we_count", 32'(n_we - b_we), (y < LC) ? 32'(LP) : 32'd0);
    chk("rd_count", 32'(n_rd - b_rd), (y < LC) ? 32'(LP) : 32'd0);
    chk("act_count", 32'(n_act - b_act), 32'(rows));
    chk("pre_count", 32'(n_pre - b_pre), 32'(rows));
    chk("ref_in_line", 32'(n_ref - b_ref), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, t;
    bit seen;
    for (int i = 0; i <= CL; i++) dpipe[i] = 17'd0;
    repeat (3) tick();
    chk("rst_cmd", 32'({cs_n, ras_n, cas_n, we_n}), 32'(NOP));
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_misc", 32'({ba, cke, dq_oe, busy, done, lb_we}), 32'b0010000);
    chk("rst_lb", 32'({lb_addr, lb_data}), 32'd0);

    reset = 1'b0;
    rel = cyc;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 1300) begin
      tick();
      line_req = 1'b0;
      t++;
      if (cyc - rel == 1039) chk("busy_pre_wrap", 32'(busy), 32'd0);
      if (cyc - rel == 1040) begin
        chk("busy_at_wrap", 32'(busy), 32'd1);
        line_y = 8'd3;
        line_req = 1'b1;
      end
      if (n_ref > 0) seen = 1'b1;
    end
    chk("ref_time", 32'(cyc - rel), 32'd1042);
    chk("ref_once", 32'(n_ref), 32'd1);
    for (int i = 0; i < RFC - 1; i++) begin
      tick();
      chk("rfc_nop", 32'({cs_n, ras_n, cas_n, we_n}), 32'(NOP));
    end
    repeat (10) tick();
    chk("wrap_req_ignored", 32'(n_act + n_rd + n_done), 32'd0);

    run_line(0, 1'b1);
    run_line(239, 1'b0);
    run_line(240, 1'b0);

    sync_refresh();
    start_req(7);
    t = 0;
    while (n_rd - rd_base < 100 && t < 500) begin tick(); t++; end
    chk("reached_read100", 32'(n_rd - rd_base), 32'd100);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_cmd", 32'({cs_n, ras_n, cas_n, we_n}), 32'(NOP));
    chk("mid_rst_addr", 32'(addr), 32'd0);
    chk("mid_rst_misc", 32'({busy, done, lb_we}), 32'd0);
    chk("mid_rst_lb", 32'({lb_addr, lb_data}), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    run_line(7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
